counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
- Run controller for the board-level n-bit free-running counter datapath.
- Turns two raw pushbuttons into clean press events and applies a switch-selected rate prescaler.
- A 4-state FSM drives the counter's Enable/Clear inputs and stops it exactly at a programmable limit.
- Sits between the KEY/SW pins and the counter; the counter itself stays outside this block.

Parameters:
- N, 24, counter width; width of Count and Limit.
- DB_CYCLES, 1000000, debounce stability window in clocks (20 ms at 50 MHz).
- DIV1, 50000000, prescaler divisor for Rate=1.
- DIV2, 5000000, prescaler divisor for Rate=2.
- DIV3, 500000, prescaler divisor for Rate=3.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  synchronous active-low reset.
- KeyStartn  in  1  raw start pushbutton, active-low, asynchronous.
- KeyStopn  in  1  raw stop pushbutton, active-low, asynchronous.
- Rate  in  2  divisor select: 0 gives divide-by-1, 1/2/3 give DIV1/DIV2/DIV3.
- Limit  in  N  terminal count.
- Count  in  N  current counter value from the datapath.
- CntEnable  out  1  counter increment strobe.
- CntClear  out  1  counter synchronous clear; has priority over CntEnable at the counter.
- Done  out  1  high while the limit has been reached.
- State  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Interface: clock is Clock; reset is Resetn, synchronous, active-low.
- Reset values: State=IDLE, CntClear=1, CntEnable=0, Done=0; prescaler=0; debounced keys=1 (released).
- All outputs are registered. Resetn low at any point returns the block to reset values at the next edge.
- Key path, per key:
  - 2-FF synchronizer.
  - Debounced level changes only after the synchronized input has differed from it for DB_CYCLES consecutive clocks; any shorter excursion restarts the window.
  - Press event is a 1-cycle pulse on a debounced 1->0 transition. Release produces no event.
- Prescaler:
  - Counts only in RUN. Cleared on entry to RUN from IDLE or DONE. Held in PAUSE.
  - tick is asserted when pre >= div-1, and pre wraps to 0 in that cycle.
  - Rate=0 gives a tick every cycle. A Rate change applies immediately; if pre already exceeds the new div-1, tick occurs next cycle.
- Effective count: eff = Count + CntEnable (current registered value), N-bit. This compensates for the datapath's one-cycle update lag.
- IDLE:
  - CntClear=1, CntEnable=0.
  - Start press -> RUN; CntClear=0 from the first RUN cycle.
- RUN:
  - On tick with eff != Limit: CntEnable=1 for one cycle.
  - On tick with eff == Limit: no enable, go to DONE.
  - Stop press -> PAUSE. Start press is ignored.
- PAUSE:
  - CntEnable=0; Count is held by the datapath.
  - Start press -> RUN with prescaler phase preserved.
  - Stop press -> IDLE.
- DONE:
  - Done=1, CntEnable=0.
  - Start press -> RUN with a 1-cycle CntClear in the first RUN cycle; CntEnable is forced 0 whenever CntClear=1.
  - Stop press -> IDLE.
- Simultaneous start and stop presses in one cycle: stop wins.
- Limit=0: the first tick in RUN goes to DONE with zero enables.
- Limit < current Count (Limit lowered mid-run): the counter runs to its N-bit wrap, then stops at Limit. No early termination.
- Count never overshoots Limit, at any Rate.
- Latency:
  - Raw key edge to press event: 2 + DB_CYCLES cycles.
  - Press event to State update: 1 cycle.
  - First CntEnable: div cycles after entering RUN from IDLE.

Decomposition:
- Shared package counter_pkg holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE;
  - rate codes RATE_X1..RATE_D3;
  - default DB_CYCLES and DIV constants.
- One sub-module, key_debounce (synchronizer + debounce + press pulse), instantiated twice.
- Prescaler and FSM live in counter_run_ctrl.

Test Plan:
- Reset check (overrides DB_CYCLES=4, DIV1=4, DIV2=3, DIV3=2; bench models the counter): hold Resetn=0 for 3 cycles -> State=0, CntClear=1, CntEnable=0, Done=0, Count=0.
- Rate=1, Limit=3: start press -> CntEnable pulses every 4 cycles, 3 pulses total; then State=3, Done=1, Count=3 held.
- Rate=0, Limit=5: start press -> CntEnable high for 5 consecutive cycles; Count ends at exactly 5 (not 6); DONE.
- Bounce rejection: 3-cycle low glitch on KeyStartn -> no state change. A 4+ cycle low -> RUN exactly 2+4+1 cycles after the edge.
- Pause/resume, Rate=2, Limit=100:
  - stop press at Count=7 -> PAUSE, Count stays 7;
  - start press -> next CntEnable arrives after the remaining prescaler phase;
  - stop, stop -> IDLE, Count=0.
- Corner cases:
  - simultaneous start and stop press in RUN -> PAUSE;
  - Limit=0 -> DONE with no CntEnable;
  - DONE + start press -> CntClear pulse, then counting from 0;
  - Resetn low mid-RUN -> IDLE next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg -- shared encodings and defaults for the counter run controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RATE_X1 = 2'd0,
    RATE_D1 = 2'd1,
    RATE_D2 = 2'd2,
    RATE_D3 = 2'd3
  } rate_t;

  localparam int DEF_DB_CYCLES = 1000000;
  localparam int DEF_DIV1      = 50000000;
  localparam int DEF_DIV2      = 5000000;
  localparam int DEF_DIV3      = 500000;

  // Bits needed to hold any value in 0..max_val (at least 1).
  function automatic int bits_for(input int max_val);
    int w;
    w = 1;
    while ((longint'(1) << w) <= longint'(max_val)) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce -- 2-FF synchronizer, stability-window debounce, press pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce
  import counter_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic key_n,
  output logic press
);

  localparam int CW = bits_for(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the current level restarts the window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_run_ctrl.sv
// ---------------------------------------------------------------------------
// counter_run_ctrl -- key-driven run/pause/stop control with rate prescaler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_run_ctrl
  import counter_pkg::*;
#(
  parameter int N         = 24,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int DIV1      = DEF_DIV1,
  parameter int DIV2      = DEF_DIV2,
  parameter int DIV3      = DEF_DIV3
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         KeyStartn,
  input  logic         KeyStopn,
  input  logic [1:0]   Rate,
  input  logic [N-1:0] Limit,
  input  logic [N-1:0] Count,
  output logic         CntEnable,
  output logic         CntClear,
  output logic         Done,
  output logic [1:0]   State
);

  localparam int MAX_DIV = (DIV1 > DIV2) ? ((DIV1 > DIV3) ? DIV1 : DIV3)
                                         : ((DIV2 > DIV3) ? DIV2 : DIV3);
  localparam int PW = bits_for(MAX_DIV - 1);

  logic          start_press;
  logic          stop_press;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic [PW-1:0] div_m1;
  logic          tick;
  logic          en_nxt;
  logic          clr_nxt;
  logic [N-1:0]  eff;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_key (
    .Clock  (Clock),
    .Resetn (Resetn),
    .key_n  (KeyStartn),
    .press  (start_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_stop_key (
    .Clock  (Clock),
    .Resetn (Resetn),
    .key_n  (KeyStopn),
    .press  (stop_press)
  );

  always_comb begin
    div_m1 = '0;
    case (rate_t'(Rate))
      RATE_D1: div_m1 = PW'(DIV1 - 1);
      RATE_D2: div_m1 = PW'(DIV2 - 1);
      RATE_D3: div_m1 = PW'(DIV3 - 1);
      default: div_m1 = '0;
    endcase
  end

  assign tick = (state == ST_RUN) && (pre >= div_m1);

  // The datapath lags one cycle behind our strobes: a pending clear means it
  // is about to read 0, a pending enable means it is about to read Count+1.
  assign eff = CntClear ? '0 : Count + {{(N-1){1'b0}}, CntEnable};

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    en_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_press && !stop_press) begin
          state_nxt = ST_RUN;
          pre_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (tick) begin
          pre_nxt = '0;
          if (eff == Limit) state_nxt = ST_DONE;
          else              en_nxt    = 1'b1;
        end else begin
          pre_nxt = pre + PW'(1);
        end
        if (stop_press) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_press)       state_nxt = ST_IDLE;
        else if (start_press) state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (stop_press) begin
          state_nxt = ST_IDLE;
        end else if (start_press) begin
          state_nxt = ST_RUN;
          pre_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    clr_nxt = (state_nxt == ST_IDLE) || (state == ST_DONE && state_nxt == ST_RUN);
    if (clr_nxt) en_nxt = 1'b0;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      pre       <= '0;
      CntEnable <= 1'b0;
      CntClear  <= 1'b1;
      Done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      CntEnable <= en_nxt;
      CntClear  <= clr_nxt;
      Done      <= (state_nxt == ST_DONE);
    end
  end

  assign State = state;

endmodule

`default_nettype wire

// File: tb/tb_counter_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_run_ctrl -- self-checking bench with counter model and scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counter_run_ctrl;

  logic        Clock;
  logic        Resetn;
  logic        KeyStartn;
  logic        KeyStopn;
  logic [1:0]  Rate;
  logic [23:0] Limit;
  logic [23:0] Count;
  logic        CntEnable;
  logic        CntClear;
  logic        Done;
  logic [1:0]  State;

  int cyc;
  int n_checks;
  int n_pass;
  int exp_q[$];
  int act_q[$];

  counter_run_ctrl #(
    .N(24), .DB_CYCLES(4), .DIV1(4), .DIV2(3), .DIV3(2)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .KeyStartn (KeyStartn),
    .KeyStopn  (KeyStopn),
    .Rate      (Rate),
    .Limit     (Limit),
    .Count     (Count),
    .CntEnable (CntEnable),
    .CntClear  (CntClear),
    .Done      (Done),
    .State     (State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Counter datapath: clear has priority over enable.
  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (!Resetn || CntClear) Count <= '0;
    else if (CntEnable)      Count <= Count + 24'd1;
  end

  always @(negedge Clock) if (CntEnable) act_q.push_back(cyc);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge Clock);
  endtask

  // Hold the keys pressed long enough to debounce, then release and settle.
  task automatic press_keys(input bit s, input bit p);
    KeyStartn = ~s;
    KeyStopn  = ~p;
    repeat (8) @(negedge Clock);
    KeyStartn = 1'b1;
    KeyStopn  = 1'b1;
    repeat (8) @(negedge Clock);
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    repeat (3) @(negedge Clock);
    n_checks++; if (State !== 2'd0) $display("FAIL reset_state: got %0d want 0", State); else n_pass++;
    n_checks++; if (CntClear !== 1'b1) $display("FAIL reset_clear: got %b want 1", CntClear); else n_pass++;
    n_checks++; if (CntEnable !== 1'b0) $display("FAIL reset_enable: got %b want 0", CntEnable); else n_pass++;
    n_checks++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else n_pass++;
    n_checks++; if (Count !== 24'd0) $display("FAIL reset_count: got %0d want 0", Count); else n_pass++;
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_rate1;
    int c, e, a;
    Rate = 2'd1; Limit = 24'd3;
    exp_q.delete(); act_q.delete();
    c = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back(c + 7 + 4 * k);
    press_keys(1'b1, 1'b0);
    wait_until(c + 30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (act_q.size() == 0) $display("FAIL rate1_enable: got no pulse want cycle %0d", e);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL rate1_enable: got cycle %0d want %0d", a, e); else n_pass++;
      end
    end
    n_checks++; if (act_q.size() != 0) $display("FAIL rate1_extra: got %0d extra pulses want 0", act_q.size()); else n_pass++;
    n_checks++; if (State !== 2'd3) $display("FAIL rate1_state: got %0d want 3", State); else n_pass++;
    n_checks++; if (Done !== 1'b1) $display("FAIL rate1_done: got %b want 1", Done); else n_pass++;
    n_checks++; if (Count !== 24'd3) $display("FAIL rate1_count: got %0d want 3", Count); else n_pass++;
  endtask

  task automatic test_rate0;
    int c, e, a;
    press_keys(1'b0, 1'b1);
    n_checks++; if (State !== 2'd0) $display("FAIL done_stop_state: got %0d want 0", State); else n_pass++;
    n_checks++; if (Count !== 24'd0) $display("FAIL done_stop_count: got %0d want 0", Count); else n_pass++;
    Rate = 2'd0; Limit = 24'd5;
    exp_q.delete(); act_q.delete();
    c = cyc;
    for (int k = 8; k <= 12; k++) exp_q.push_back(c + k);
    press_keys(1'b1, 1'b0);
    wait_until(c + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (act_q.size() == 0) $display("FAIL rate0_enable: got no pulse want cycle %0d", e);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL rate0_enable: got cycle %0d want %0d", a, e); else n_pass++;
      end
    end
    n_checks++; if (act_q.size() != 0) $display("FAIL rate0_extra: got %0d extra pulses want 0", act_q.size()); else n_pass++;
    n_checks++; if (Count !== 24'd5) $display("FAIL rate0_count: got %0d want 5", Count); else n_pass++;
    n_checks++; if (State !== 2'd3) $display("FAIL rate0_state: got %0d want 3", State); else n_pass++;
  endtask

  task automatic test_done_restart;
    int c, e, a;
    exp_q.delete(); act_q.delete();
    c = cyc;
    for (int k = 8; k <= 12; k++) exp_q.push_back(c + k);
    KeyStartn = 1'b0;
    wait_until(c + 7);
    n_checks++; if (State !== 2'd1) $display("FAIL restart_state: got %0d want 1", State); else n_pass++;
    n_checks++; if (CntClear !== 1'b1) $display("FAIL restart_clear_pulse: got %b want 1", CntClear); else n_pass++;
    wait_until(c + 8);
    n_checks++; if (CntClear !== 1'b0) $display("FAIL restart_clear_end: got %b want 0", CntClear); else n_pass++;
    n_checks++; if (Count !== 24'd0) $display("FAIL restart_count0: got %0d want 0", Count); else n_pass++;
    KeyStartn = 1'b1;
    wait_until(c + 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (act_q.size() == 0) $display("FAIL restart_enable: got no pulse want cycle %0d", e);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL restart_enable: got cycle %0d want %0d", a, e); else n_pass++;
      end
    end
    n_checks++; if (act_q.size() != 0) $display("FAIL restart_extra: got %0d extra pulses want 0", act_q.size()); else n_pass++;
    n_checks++; if (Count !== 24'd5) $display("FAIL restart_count: got %0d want 5", Count); else n_pass++;
    press_keys(1'b0, 1'b1);
  endtask

  task automatic test_bounce;
    int c;
    Rate = 2'd3; Limit = 24'd100;
    c = cyc;
    KeyStartn = 1'b0;
    wait_until(c + 3);
    KeyStartn = 1'b1;
    wait_until(c + 14);
    n_checks++; if (State !== 2'd0) $display("FAIL bounce_glitch: got state %0d want 0", State); else n_pass++;
    c = cyc;
    KeyStartn = 1'b0;
    wait_until(c + 6);
    n_checks++; if (State !== 2'd0) $display("FAIL bounce_early: got state %0d want 0", State); else n_pass++;
    wait_until(c + 7);
    n_checks++; if (State !== 2'd1) $display("FAIL bounce_latency: got state %0d want 1", State); else n_pass++;
    wait_until(c + 8);
    KeyStartn = 1'b1;
    wait_until(c + 16);
  endtask

  task automatic test_simultaneous;
    logic [23:0] held;
    press_keys(1'b1, 1'b1);
    n_checks++; if (State !== 2'd2) $display("FAIL simul_state: got %0d want 2", State); else n_pass++;
    held = Count;
    repeat (4) @(negedge Clock);
    n_checks++; if (Count !== held) $display("FAIL simul_hold: got %0d want %0d", Count, held); else n_pass++;
    press_keys(1'b0, 1'b1);
    n_checks++; if (State !== 2'd0) $display("FAIL simul_idle: got %0d want 0", State); else n_pass++;
  endtask

  task automatic test_pause_resume;
    int c0, c1, e, a;
    Rate = 2'd2; Limit = 24'd100;
    exp_q.delete(); act_q.delete();
    c0 = cyc;
    for (int k = 1; k <= 7; k++) exp_q.push_back(c0 + 7 + 3 * k);
    press_keys(1'b1, 1'b0);
    wait_until(c0 + 23);
    press_keys(1'b0, 1'b1);
    n_checks++; if (State !== 2'd2) $display("FAIL pause_state: got %0d want 2", State); else n_pass++;
    n_checks++; if (Count !== 24'd7) $display("FAIL pause_count: got %0d want 7", Count); else n_pass++;
    c1 = cyc;
    for (int k = 0; k < 6; k++) exp_q.push_back(c1 + 8 + 3 * k);
    press_keys(1'b1, 1'b0);
    wait_until(c1 + 17);
    press_keys(1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (act_q.size() == 0) $display("FAIL pause_enable: got no pulse want cycle %0d", e);
      else begin
        a = act_q.pop_front();
        if (a !== e) $display("FAIL pause_enable: got cycle %0d want %0d", a, e); else n_pass++;
      end
    end
    n_checks++; if (act_q.size() != 0) $display("FAIL pause_extra: got %0d extra pulses want 0", act_q.size()); else n_pass++;
    n_checks++; if (Count !== 24'd13) $display("FAIL pause_count2: got %0d want 13", Count); else n_pass++;
    press_keys(1'b0, 1'b1);
    n_checks++; if (State !== 2'd0) $display("FAIL pause_idle: got %0d want 0", State); else n_pass++;
    n_checks++; if (Count !== 24'd0) $display("FAIL pause_idle_count: got %0d want 0", Count); else n_pass++;
  endtask

  task automatic test_limit0;
    Rate = 2'd1; Limit = 24'd0;
    act_q.delete();
    press_keys(1'b1, 1'b0);
    n_checks++; if (State !== 2'd3) $display("FAIL limit0_state: got %0d want 3", State); else n_pass++;
    n_checks++; if (Done !== 1'b1) $display("FAIL limit0_done: got %b want 1", Done); else n_pass++;
    n_checks++; if (act_q.size() != 0) $display("FAIL limit0_enables: got %0d pulses want 0", act_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midrun;
    press_keys(1'b0, 1'b1);
    Rate = 2'd0; Limit = 24'd100;
    press_keys(1'b1, 1'b0);
    n_checks++; if (State !== 2'd1) $display("FAIL midrun_running: got %0d want 1", State); else n_pass++;
    Resetn = 1'b0;
    @(negedge Clock);
    n_checks++; if (State !== 2'd0) $display("FAIL midrun_state: got %0d want 0", State); else n_pass++;
    n_checks++; if (CntClear !== 1'b1) $display("FAIL midrun_clear: got %b want 1", CntClear); else n_pass++;
    n_checks++; if (CntEnable !== 1'b0) $display("FAIL midrun_enable: got %b want 0", CntEnable); else n_pass++;
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    Resetn = 1'b0; KeyStartn = 1'b1; KeyStopn = 1'b1;
    Rate = 2'd0; Limit = 24'd0;
    @(negedge Clock);
    test_reset();
    test_rate1();
    test_rate0();
    test_done_restart();
    test_bounce();
    test_simultaneous();
    test_pause_resume();
    test_limit0();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
